// File: rtl/i2c_master_byte_engine.sv
// I2C initiator byte engine: one START / byte / STOP command per cmd handshake on open-drain pad triplets.
// Latency: START 3 quarters (repeated START 4), byte 36 quarters, STOP 4; one quarter = PRESCALE clk.
// Backpressure: cmd_ready is low while a command executes and returns 1 clk after its final quarter.
// Optional I2C_CLOCK_STRETCH_EN: while SCL is released in Q2, a target holding SCL low freezes the quarter counter.
module i2c_master_byte_engine #(
  parameter int PRESCALE = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_write,
  input  logic       cmd_read,
  input  logic       cmd_ack,
  input  logic       cmd_stop,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ack_err,
  output logic       busy,
  output logic       bus_held,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_t,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_START, S_BIT, S_STOP} state_t;

  localparam logic [15:0] PS_M1 = 16'(PRESCALE - 1);

  state_t      state;
  logic [1:0]  q;          // quarter within the current field
  logic [3:0]  bitn;       // 0..7 data bits, 8 = ACK slot
  logic [15:0] qcnt;
  logic        c_byte, c_wr, c_ack, c_stop, c_rs;
  logic [7:0]  c_tx;
  logic [7:0]  rx_sh;
  logic        ack_smp;

  // Pads are open-drain: only the tristate enables move.
  assign i2c_scl_o = 1'b0;
  assign i2c_sda_o = 1'b0;

  logic op_byte, op_start, op_stop, active, stall, tick;
  logic [1:0] q_nxt, last_q;
  logic [3:0] bit_nxt;

  assign op_byte  = cmd_write | cmd_read;
  assign op_start = cmd_start | (op_byte & ~bus_held);
  // A lone STOP on an idle bus has nothing to terminate.
  assign op_stop  = cmd_stop & (bus_held | op_start);
  assign active   = (state == S_START) || (state == S_BIT) || (state == S_STOP);
  assign q_nxt    = q + 2'd1;
  assign bit_nxt  = bitn + 4'd1;
  assign last_q   = (state == S_START && !c_rs) ? 2'd2 : 2'd3;

`ifdef I2C_CLOCK_STRETCH_EN
  assign stall = active && (q == 2'd2) && i2c_scl_t && !i2c_scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = i2c_scl_i;
  assign stall = 1'b0;
`endif

  assign tick = active && !stall && (qcnt == PS_M1);

  // Line levels {scl_t, sda_t} for a given field and quarter.
  function automatic logic [1:0] lines(input state_t st, input logic [1:0] qq, input logic [3:0] b,
                                       input logic wr, input logic [7:0] tx, input logic ack,
                                       input logic rs);
    logic [1:0] r;
    logic [2:0] idx;
    r   = 2'b11;
    idx = ~b[2:0];
    case (st)
      S_START: begin
        if (rs) begin
          case (qq)
            2'd0:    r = 2'b01;
            2'd1:    r = 2'b11;
            2'd2:    r = 2'b10;
            default: r = 2'b00;
          endcase
        end else begin
          r = (qq == 2'd2) ? 2'b00 : 2'b10;
        end
      end
      S_BIT: begin
        r[1] = qq[1];
        if (b == 4'd8) r[0] = wr ? 1'b1 : ~ack;
        else           r[0] = wr ? tx[idx] : 1'b1;
      end
      S_STOP: begin
        case (qq)
          2'd0:    r = 2'b00;
          2'd1:    r = 2'b10;
          default: r = 2'b11;
        endcase
      end
      S_HOLD:  r = 2'b01;
      default: r = 2'b11;
    endcase
    return r;
  endfunction

  // Command FSM: accept, walk START/BIT/STOP quarters, register all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      q         <= 2'd0;
      bitn      <= 4'd0;
      qcnt      <= 16'd0;
      c_byte    <= 1'b0;
      c_wr      <= 1'b0;
      c_ack     <= 1'b0;
      c_stop    <= 1'b0;
      c_rs      <= 1'b0;
      c_tx      <= 8'h00;
      rx_sh     <= 8'h00;
      ack_smp   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      ack_err   <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      bus_held  <= 1'b0;
      i2c_scl_t <= 1'b1;
      i2c_sda_t <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      ack_err  <= 1'b0;
      if (active && !stall) qcnt <= tick ? 16'd0 : qcnt + 16'd1;
      case (state)
        S_IDLE, S_HOLD: begin
          if (cmd_valid && cmd_ready && (op_start || op_byte || op_stop)) begin
            c_byte    <= op_byte;
            c_wr      <= cmd_write;
            c_ack     <= cmd_ack;
            c_stop    <= cmd_stop;
            c_tx      <= tx_data;
            c_rs      <= bus_held;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            qcnt      <= 16'd0;
            q         <= 2'd0;
            bitn      <= 4'd0;
            if (op_start) begin
              state <= S_START;
              {i2c_scl_t, i2c_sda_t} <= lines(S_START, 2'd0, 4'd0, cmd_write, tx_data, cmd_ack, bus_held);
            end else if (op_byte) begin
              state <= S_BIT;
              {i2c_scl_t, i2c_sda_t} <= lines(S_BIT, 2'd0, 4'd0, cmd_write, tx_data, cmd_ack, bus_held);
            end else begin
              state <= S_STOP;
              {i2c_scl_t, i2c_sda_t} <= lines(S_STOP, 2'd0, 4'd0, cmd_write, tx_data, cmd_ack, bus_held);
            end
          end
        end
        default: begin
          if (tick) begin
            // Sample SDA on the last clk of Q2, while SCL is high.
            if (state == S_BIT && q == 2'd2) begin
              if (bitn != 4'd8) rx_sh <= {rx_sh[6:0], i2c_sda_i};
              else              ack_smp <= i2c_sda_i;
            end
            if (q != last_q) begin
              q <= q_nxt;
              {i2c_scl_t, i2c_sda_t} <= lines(state, q_nxt, bitn, c_wr, c_tx, c_ack, c_rs);
            end else begin
              q <= 2'd0;
              case (state)
                S_START: begin
                  bus_held <= 1'b1;
                  if (c_byte) begin
                    state <= S_BIT;
                    bitn  <= 4'd0;
                    {i2c_scl_t, i2c_sda_t} <= lines(S_BIT, 2'd0, 4'd0, c_wr, c_tx, c_ack, c_rs);
                  end else if (c_stop) begin
                    state <= S_STOP;
                    {i2c_scl_t, i2c_sda_t} <= lines(S_STOP, 2'd0, 4'd0, c_wr, c_tx, c_ack, c_rs);
                  end else begin
                    state <= S_HOLD; busy <= 1'b0; cmd_ready <= 1'b1;
                    {i2c_scl_t, i2c_sda_t} <= lines(S_HOLD, 2'd0, 4'd0, c_wr, c_tx, c_ack, c_rs);
                  end
                end
                S_BIT: begin
                  if (bitn != 4'd8) begin
                    bitn <= bit_nxt;
                    {i2c_scl_t, i2c_sda_t} <= lines(S_BIT, 2'd0, bit_nxt, c_wr, c_tx, c_ack, c_rs);
                  end else begin
                    if (c_wr) ack_err <= ack_smp;
                    else begin
                      rx_valid <= 1'b1;
                      rx_data  <= rx_sh;
                    end
                    if (c_stop) begin
                      state <= S_STOP;
                      {i2c_scl_t, i2c_sda_t} <= lines(S_STOP, 2'd0, 4'd0, c_wr, c_tx, c_ack, c_rs);
                    end else begin
                      state <= S_HOLD; busy <= 1'b0; cmd_ready <= 1'b1;
                      {i2c_scl_t, i2c_sda_t} <= lines(S_HOLD, 2'd0, 4'd0, c_wr, c_tx, c_ack, c_rs);
                    end
                  end
                end
                default: begin
                  state    <= S_IDLE;
                  bus_held <= 1'b0;
                  busy     <= 1'b0;
                  cmd_ready <= 1'b1;
                  {i2c_scl_t, i2c_sda_t} <= 2'b11;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// Directed bench for i2c_master_byte_engine at PRESCALE=4 with a behavioural target on the bus.
// SDA bit and received-byte expectations are queued when a command is issued and popped as the DUT produces them.
// A watchdog bounds total run time.
module tb_i2c_master_byte_engine;
  localparam int P = 4;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STR = 20;
`else
  localparam int STR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_start, cmd_write, cmd_read, cmd_ack, cmd_stop;
  logic [7:0] tx_data;
  logic cmd_ready, rx_valid, ack_err, busy, bus_held;
  logic [7:0] rx_data;
  logic scl_o, scl_t, sda_o, sda_t;
  logic tgt_sda, stretch;

  always #5 clk = ~clk;

  i2c_master_byte_engine #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read),
    .cmd_ack(cmd_ack), .cmd_stop(cmd_stop), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .ack_err(ack_err),
    .busy(busy), .bus_held(bus_held),
    .i2c_scl_i(scl_t & ~stretch), .i2c_scl_o(scl_o), .i2c_scl_t(scl_t),
    .i2c_sda_i(sda_t & tgt_sda), .i2c_sda_o(sda_o), .i2c_sda_t(sda_t)
  );

  int total = 0;
  int passed = 0;
  bit exp_bits[$];
  logic [7:0] exp_rx[$];
  int ack_pulses = 0, ack_cycles = 0, rxv_pulses = 0, rxv_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse counters and rx_data scoreboard.
  initial begin
    logic ack_prev, rxv_prev;
    ack_prev = 1'b0;
    rxv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_err) ack_cycles++;
      if (ack_err && !ack_prev) ack_pulses++;
      if (rx_valid) rxv_cycles++;
      if (rx_valid && !rxv_prev) begin
        rxv_pulses++;
        check("rx_data", {24'h0, rx_data}, exp_rx.size() > 0 ? {24'h0, exp_rx.pop_front()} : 32'hFFFF);
      end
      ack_prev = ack_err;
      rxv_prev = rx_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_bits(input logic [8:0] b);
    for (int i = 8; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic wait_scl(input logic v);
    int n;
    n = 0;
    while (scl_t !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scl_wait", {31'h0, scl_t}, {31'h0, v});
  endtask

  task automatic send(input logic s, input logic w, input logic r, input logic a,
                      input logic p, input logic [7:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
    cmd_start = s; cmd_write = w; cmd_read = r; cmd_ack = a; cmd_stop = p; tx_data = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_start = 1'b0; cmd_write = 1'b0; cmd_read = 1'b0; cmd_stop = 1'b0;
    cmd_ack = 1'($urandom_range(0, 1));
    tx_data = 8'($urandom);
  endtask

  task automatic wait_done(output int cyc, output logic rise_scl);
    logic prev;
    cyc = 0;
    rise_scl = 1'b0;
    prev = sda_t;
    while (busy && cyc < 3000) begin
      if (!prev && sda_t) rise_scl = scl_t;
      prev = sda_t;
      cyc++;
      @(negedge clk);
    end
    if (!prev && sda_t) rise_scl = scl_t;
    check("busy_clear", {31'h0, busy}, 32'h0);
  endtask

  // Behavioural target: drives read data / ACK while SCL low, checks master SDA while SCL high.
  task automatic target(input logic rd, input logic [7:0] d, input logic ackv);
    for (int b = 0; b < 9; b++) begin
      wait_scl(1'b0);
      if (rd) tgt_sda = (b < 8) ? d[7 - b] : 1'b1;
      else    tgt_sda = (b < 8) ? 1'b1 : ackv;
      wait_scl(1'b1);
      check("sda_bit", {31'h0, sda_t}, exp_bits.size() > 0 ? {31'h0, exp_bits.pop_front()} : 32'h2);
    end
    wait_scl(1'b0);
    tgt_sda = 1'b1;
  endtask

  initial begin
    int cyc, a0, a1, r0, r1;
    logic rise;
    logic [1:0] cap [16];

    rst = 1'b1; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0; cmd_read = 1'b0;
    cmd_ack = 1'b0; cmd_stop = 1'b0; tx_data = 8'h00; tgt_sda = 1'b1; stretch = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lines", {30'h0, scl_t, sda_t}, 32'h3);
    check("rst_flags", {27'h0, cmd_ready, busy, bus_held, rx_valid, ack_err}, 32'h10);
    check("rst_rx", {24'h0, rx_data}, 32'h0);
    check("pad_o", {30'h0, scl_o, sda_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // START + write A0, ACKed; bus stays held with SCL low.
    push_bits({8'hA0, 1'b1});
    a0 = ack_pulses;
    send(1, 1, 0, 0, 0, 8'hA0);
    check("start_q0", {28'h0, scl_t, sda_t, busy, cmd_ready}, 32'hA);
    fork
      target(1'b0, 8'h00, 1'b0);
      wait_done(cyc, rise);
    join
    check("wr_a0_cycles", cyc, 39 * P);
    repeat (2) @(negedge clk);
    check("wr_a0_ackerr", ack_pulses - a0, 0);
    check("wr_a0_hold", {29'h0, bus_held, scl_t, cmd_ready}, 32'h5);

    // Write 3C, NACKed: single-cycle ack_err, 36 quarters.
    push_bits({8'h3C, 1'b1});
    a0 = ack_pulses; a1 = ack_cycles;
    send(0, 1, 0, 0, 0, 8'h3C);
    fork
      target(1'b0, 8'h00, 1'b1);
      wait_done(cyc, rise);
    join
    check("wr_3c_cycles", cyc, 36 * P);
    repeat (2) @(negedge clk);
    check("wr_3c_ackerr_pulses", ack_pulses - a0, 1);
    check("wr_3c_ackerr_width", ack_cycles - a1, 1);

    // Read 5C with NACK and STOP.
    push_bits({8'hFF, 1'b1});
    exp_rx.push_back(8'h5C);
    r0 = rxv_pulses; r1 = rxv_cycles;
    send(0, 0, 1, 0, 1, 8'h00);
    fork
      target(1'b1, 8'h5C, 1'b0);
      wait_done(cyc, rise);
    join
    check("rd_cycles", cyc, 40 * P);
    repeat (2) @(negedge clk);
    check("rd_rxv_pulses", rxv_pulses - r0, 1);
    check("rd_rxv_width", rxv_cycles - r1, 1);
    check("rd_rx_data", {24'h0, rx_data}, 32'h5C);
    check("rd_stop_rise_scl_high", {31'h0, rise}, 32'h1);
    check("rd_released", {29'h0, bus_held, scl_t, sda_t}, 32'h3);

    // Write, then START + write A1 from the held bus: repeated START.
    push_bits({8'hA0, 1'b1});
    send(1, 1, 0, 0, 0, 8'hA0);
    fork
      target(1'b0, 8'h00, 1'b0);
      wait_done(cyc, rise);
    join
    push_bits({8'hA1, 1'b1});
    send(1, 1, 0, 0, 0, 8'hA1);
    for (int i = 0; i < 16; i++) begin
      cap[i] = {scl_t, sda_t};
      @(negedge clk);
    end
    check("rs_q0_sda_up_scl_low", {30'h0, cap[1]}, 32'h1);
    check("rs_q1_scl_up", {30'h0, cap[5]}, 32'h3);
    check("rs_q2_sda_down_scl_high", {30'h0, cap[9]}, 32'h2);
    check("rs_q3_scl_down", {30'h0, cap[13]}, 32'h0);
    fork
      target(1'b0, 8'h00, 1'b0);
      wait_done(cyc, rise);
    join
    check("rs_held", {31'h0, bus_held}, 32'h1);

    // Lone STOP on the held bus.
    send(0, 0, 0, 0, 1, 8'h00);
    wait_done(cyc, rise);
    check("stop_cycles", cyc, 4 * P);
    check("stop_rise_scl_high", {31'h0, rise}, 32'h1);
    check("stop_released", {29'h0, bus_held, scl_t, sda_t}, 32'h3);

    // Write from idle inserts START; reset during bit 4 aborts without STOP.
    send(0, 1, 0, 0, 0, 8'hFF);
    check("auto_start", {30'h0, scl_t, sda_t}, 32'h2);
    for (int i = 0; i < 5; i++) begin
      wait_scl(1'b0);
      wait_scl(1'b1);
    end
    a0 = ack_pulses; r0 = rxv_pulses;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_lines", {30'h0, scl_t, sda_t}, 32'h3);
    check("rst_mid_flags", {27'h0, cmd_ready, busy, bus_held, rx_valid, ack_err}, 32'h10);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_discard", {29'h0, busy, scl_t, sda_t}, 32'h3);
    check("rst_no_pulses", (ack_pulses - a0) + (rxv_pulses - r0), 0);

    // START + write 55 + STOP with SCL held low by the target for 20 clks in Q2 of bit 3.
    push_bits({8'h55, 1'b1});
    send(1, 1, 0, 0, 1, 8'h55);
    fork
      target(1'b0, 8'h00, 1'b0);
      wait_done(cyc, rise);
      begin
        for (int i = 0; i < 4; i++) begin
          wait_scl(1'b0);
          wait_scl(1'b1);
        end
        stretch = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        stretch = 1'b0;
      end
    join
    check("stretch_cycles", cyc, 43 * P + STR);

    // Empty command and lone STOP on an idle bus: accepted, no activity.
    send(0, 0, 0, 0, 0, 8'h00);
    check("empty_noop", {28'h0, cmd_ready, busy, scl_t, sda_t}, 32'hB);
    send(0, 0, 0, 0, 1, 8'h00);
    repeat (3) @(negedge clk);
    check("idle_stop_noop", {27'h0, cmd_ready, busy, bus_held, scl_t, sda_t}, 32'h13);

    check("scoreboard_drained", exp_bits.size() + exp_rx.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
